uart_result_reporter: RTL
=========================

# uart_result_reporter

Downstream consumer of the system controller's classification outputs. It takes the BNN result pulse and digit plus the 4-bit status code, formats them as short ASCII messages, and serialises them on a single UART TX pin (8N1) so a host can log inferences without reading the 7-segment display. Transmit-only. Runs in the main `clk` domain beside the controller.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000, main clock frequency.
- `BAUD_RATE`, default 115200, UART bit rate.
- `clk`  in  1  main system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `result_valid`  in  1  single-cycle pulse; `result_in` is valid in that cycle.
- `result_in`  in  4  classified digit from the BNN, 0–9.
- `status_code`  in  4  controller status code; level signal.
- `uart_tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a message is in flight or pending.
- `overflow_cnt`  out  8  saturating count of result messages overwritten before transmission.

## Operation
- Divisor: `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE` (integer truncation). Elaboration fails if the divisor is < 2.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Result message (4 bytes): `R` (0x52), digit, CR (0x0D), LF (0x0A).
  - Digit is `0x30 + result_in` for inputs 0–9.
  - Digit is `?` (0x3F) for inputs 10–15, matching the blank display.
- Status message (4 bytes): `S` (0x53), hex char, CR, LF.
  - Hex char is `0`–`9` for values 0–9 and uppercase `A`–`F` for 10–15.
- Pending slots (one each):
  - `result_valid` sets `res_pend` and stores the digit.
  - If `res_pend` is already set, the stored digit is overwritten and `overflow_cnt` increments, saturating at 255.
- Message selection: the FSM snapshots the chosen message's byte when it leaves IDLE and clears that pending flag on the same edge. An event arriving during transmission sets the pending slot again.
- Priority: when both slots are pending in IDLE, the result message is sent first.
- FSM states:
  - IDLE → START when any slot is pending.
  - START → DATA after one bit time.
  - DATA → STOP after 8 bit times.
  - STOP → NEXT after one bit time.
  - NEXT → START if byte index < 3 (index increments). Otherwise NEXT → IDLE and the index clears.
- `busy` = (state ≠ IDLE) | `res_pend` | `stat_pend`.

## Timing
- Reset values: `uart_tx`=1, `busy`=0, `overflow_cnt`=0, state=IDLE, both pending flags=0, byte index=0, `status_prev`=0.
- Reset mid-frame: `uart_tx` is high from the edge after `rst_n` is sampled low. The partial frame is abandoned and all pending data is dropped.
- Latency: if `result_valid` is sampled high at edge k, `uart_tx` is low from edge k+2 (registered output), provided the FSM is IDLE.
- Within a message, the next start bit follows the stop bit after exactly one NEXT cycle, during which the line stays high.
- One 4-byte message lasts `4*(10*CLKS_PER_BIT + 1)` cycles, NEXT cycles included.
- `result_valid` coinciding with the edge that leaves IDLE for a result: the new result goes to the pending slot. It is not merged into the message already selected, and `overflow_cnt` does not increment.

## Configuration
- `STATUS_REPORT_EN` defined:
  - `status_prev` is registered every cycle.
  - `status_code ≠ status_prev` sets `stat_pend`. The hex char is taken from the latest `status_code` at the moment the message is selected.
  - A nonzero status right after reset is reported once.
- `STATUS_REPORT_EN` undefined:
  - The status slot, comparator and `S` message are removed.
  - `status_code` is ignored and only result messages are sent.

## Test plan
Common setup: `CLK_FREQ_HZ`=1_000_000, `BAUD_RATE`=100_000, giving `CLKS_PER_BIT`=10.
- Single result: pulse `result_valid` with `result_in`=7 → `uart_tx` low 2 cycles later. The UART monitor decodes 0x52 0x37 0x0D 0x0A. `busy` drops after 404 cycles.
- Out-of-range digit: `result_in`=12 → decoded second byte is 0x3F.
- Overflow: three pulses (3, 5, 9), the second and third during the first message → messages for 3 then 9; `overflow_cnt`=1.
- Simultaneous events (`STATUS_REPORT_EN` defined): `status_code` 0→4 in the same cycle as `result_valid` with 2 → `R2\r\n` then `S4\r\n`, with 1 idle cycle between them.
- Reset mid-frame: assert `rst_n`=0 during a data bit → `uart_tx`=1 on the next edge; `busy`=0 and `overflow_cnt`=0 after release, and there is no further output.
- Macro off: toggle `status_code` through 1, 2, 3 with no results → `uart_tx` stays high and `busy` stays 0.

Source files
------------

// File: rtl/uart_result_reporter.sv
// ============================================================================
// uart_result_reporter
// ----------------------------------------------------------------------------
// Formats BNN classification results (and, optionally, controller status
// changes) as short ASCII messages and serialises them on a transmit-only
// 8N1 UART line so a host can log inferences.
//
//   Result message : 'R', digit ('0'..'9', or '?' for 10..15), CR, LF
//   Status message : 'S', hex char ('0'..'9','A'..'F'), CR, LF
//
// Parameters
//   CLK_FREQ_HZ   main clock frequency in Hz
//   BAUD_RATE     UART bit rate; CLK_FREQ_HZ / BAUD_RATE must be >= 2
//
// Ports
//   clk           main clock, all logic on the rising edge
//   rst_n         synchronous active-low reset
//   result_valid  single-cycle strobe qualifying result_in
//   result_in     classified digit (0..9; 10..15 report as '?')
//   status_code   controller status level (used only with STATUS_REPORT_EN)
//   uart_tx       serial output, idles high, registered
//   busy          high while a message is in flight or pending
//   overflow_cnt  saturating count of pending results overwritten unsent
//
// Build option
//   STATUS_REPORT_EN  when defined, every change of status_code queues an
//                     'S' message. When undefined status_code is ignored.
// ============================================================================
module uart_result_reporter #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       result_valid,
   input  logic [3:0] result_in,
   input  logic [3:0] status_code,
   output logic       uart_tx,
   output logic       busy,
   output logic [7:0] overflow_cnt
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_divisor
         $error("uart_result_reporter: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_NEXT
   } state_t;

   // ------------------------------------------------------------------------
   // Character lookup tables
   // ------------------------------------------------------------------------
   // Digits 10..15 print as '?' to match the blanked 7-segment display.
   logic [7:0] digit_lut [16];

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_digit_lut
         if (gi < 10) begin : g_num
            assign digit_lut[gi] = 8'(8'h30 + gi);
         end else begin : g_blank
            assign digit_lut[gi] = 8'h3F;
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t           state_reg,        state_next;
   logic [CNT_W-1:0] baud_cnt_reg,     baud_cnt_next;
   logic [2:0]       bit_cnt_reg,      bit_cnt_next;
   logic [1:0]       byte_idx_reg,     byte_idx_next;
   logic [7:0]       char_reg,         char_next;
   logic             msg_is_stat_reg,  msg_is_stat_next;
   logic             tx_reg,           tx_next;
   logic             res_pend_reg,     res_pend_next;
   logic [3:0]       res_digit_reg,    res_digit_next;
   logic [7:0]       overflow_cnt_reg, overflow_cnt_next;

   logic             idle;
   logic             take_res;
   logic             take_stat;
   logic             stat_pend;
   logic [7:0]       stat_char;
   logic             baud_done;
   logic [7:0]       cur_byte;

   assign idle      = (state_reg == ST_IDLE);
   assign baud_done = (baud_cnt_reg == BAUD_LAST);

   // Result messages win when both slots are waiting in IDLE.
   assign take_res  = idle & res_pend_reg;
   assign take_stat = idle & stat_pend & ~res_pend_reg;

   // ------------------------------------------------------------------------
   // Status slot (optional)
   // ------------------------------------------------------------------------
`ifdef STATUS_REPORT_EN
   logic [7:0] hex_lut [16];
   logic       stat_pend_reg, stat_pend_next;
   logic [3:0] status_prev_reg;

   generate
      for (gi = 0; gi < 16; gi++) begin : g_hex_lut
         if (gi < 10) begin : g_num
            assign hex_lut[gi] = 8'(8'h30 + gi);
         end else begin : g_alpha
            // 'A' is 0x41 = 0x37 + 10
            assign hex_lut[gi] = 8'(8'h37 + gi);
         end
      end
   endgenerate

   // A fresh change re-arms the slot even on the edge that consumes it, so
   // a change landing during selection is never lost.
   always_comb begin
      stat_pend_next = stat_pend_reg;
      if (status_code != status_prev_reg) begin
         stat_pend_next = 1'b1;
      end else if (take_stat) begin
         stat_pend_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_pend_reg   <= 1'b0;
         status_prev_reg <= 4'h0;
      end else begin
         stat_pend_reg   <= stat_pend_next;
         status_prev_reg <= status_code;
      end
   end

   assign stat_pend = stat_pend_reg;
   // The reported value is the live code at selection time, not the one
   // that triggered the change.
   assign stat_char = hex_lut[status_code];
`else
   logic unused_status_code;

   assign unused_status_code = ^status_code;
   assign stat_pend          = 1'b0;
   assign stat_char          = 8'h00;
`endif

   // ------------------------------------------------------------------------
   // Result slot
   // ------------------------------------------------------------------------
   // A strobe on the selection edge refills the slot for the next message;
   // only a strobe hitting a slot that stays occupied counts as overflow.
   always_comb begin
      res_pend_next     = res_pend_reg;
      res_digit_next    = res_digit_reg;
      overflow_cnt_next = overflow_cnt_reg;
      if (result_valid) begin
         res_pend_next  = 1'b1;
         res_digit_next = result_in;
         if (res_pend_reg && !take_res && (overflow_cnt_reg != 8'hFF)) begin
            overflow_cnt_next = overflow_cnt_reg + 8'd1;
         end
      end else if (take_res) begin
         res_pend_next = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Byte currently on the wire
   // ------------------------------------------------------------------------
   always_comb begin
      case (byte_idx_reg)
         2'd0:    cur_byte = msg_is_stat_reg ? 8'h53 : 8'h52;
         2'd1:    cur_byte = char_reg;
         2'd2:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   // ------------------------------------------------------------------------
   // Transmit FSM: next state and line value
   // ------------------------------------------------------------------------
   // tx_next is the line level for the current state; registering it gives
   // the one-cycle output delay (strobe at edge k -> start bit from k+2).
   always_comb begin
      state_next       = state_reg;
      baud_cnt_next    = baud_cnt_reg;
      bit_cnt_next     = bit_cnt_reg;
      byte_idx_next    = byte_idx_reg;
      char_next        = char_reg;
      msg_is_stat_next = msg_is_stat_reg;
      tx_next          = 1'b1;

      case (state_reg)
         ST_IDLE: begin
            if (take_res || take_stat) begin
               state_next       = ST_START;
               baud_cnt_next    = '0;
               byte_idx_next    = 2'd0;
               msg_is_stat_next = take_stat;
               char_next        = take_res ? digit_lut[res_digit_reg] : stat_char;
            end
         end

         ST_START: begin
            tx_next = 1'b0;
            if (baud_done) begin
               state_next    = ST_DATA;
               baud_cnt_next = '0;
               bit_cnt_next  = 3'd0;
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end

         ST_DATA: begin
            tx_next = cur_byte[bit_cnt_reg];
            if (baud_done) begin
               baud_cnt_next = '0;
               if (bit_cnt_reg == 3'd7) begin
                  state_next = ST_STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end

         ST_STOP: begin
            if (baud_done) begin
               state_next    = ST_NEXT;
               baud_cnt_next = '0;
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end

         ST_NEXT: begin
            // Single high cycle separating bytes of one message.
            baud_cnt_next = '0;
            if (byte_idx_reg != 2'd3) begin
               byte_idx_next = byte_idx_reg + 2'd1;
               state_next    = ST_START;
            end else begin
               byte_idx_next = 2'd0;
               state_next    = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= ST_IDLE;
         baud_cnt_reg     <= '0;
         bit_cnt_reg      <= 3'd0;
         byte_idx_reg     <= 2'd0;
         char_reg         <= 8'h00;
         msg_is_stat_reg  <= 1'b0;
         tx_reg           <= 1'b1;
         res_pend_reg     <= 1'b0;
         res_digit_reg    <= 4'h0;
         overflow_cnt_reg <= 8'h00;
      end else begin
         state_reg        <= state_next;
         baud_cnt_reg     <= baud_cnt_next;
         bit_cnt_reg      <= bit_cnt_next;
         byte_idx_reg     <= byte_idx_next;
         char_reg         <= char_next;
         msg_is_stat_reg  <= msg_is_stat_next;
         tx_reg           <= tx_next;
         res_pend_reg     <= res_pend_next;
         res_digit_reg    <= res_digit_next;
         overflow_cnt_reg <= overflow_cnt_next;
      end
   end

   assign uart_tx      = tx_reg;
   assign busy         = ~idle | res_pend_reg | stat_pend;
   assign overflow_cnt = overflow_cnt_reg;

endmodule
